// File: rtl/mesh_xbar_reg_pkg.sv
// Shared definitions for the mesh router crossbar: selector sizing,
// mesh port indices and packed-field helpers.
package mesh_xbar_pkg;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int EAST  = 2;
  localparam int SOUTH = 3;
  localparam int WEST  = 4;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB position of the k-th w-bit field of a packed port vector.
  function automatic int field_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/mesh_xbar_reg_out_reg.sv
// One-entry valid/ready register slice for a single crossbar output.
// Optional saturating flit counter under XBAR_FLIT_CNT_EN.
module xbar_out_reg #(
  parameter int DATA_WIDTH = 8
`ifdef XBAR_FLIT_CNT_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
`ifdef XBAR_FLIT_CNT_EN
  output logic [CNT_WIDTH-1:0]  cnt_o,
`endif
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  valid_d, valid_q;

  // Load wins over drain so a full-rate stream keeps the slice occupied.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef XBAR_FLIT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  // Count downstream handshakes, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && ready_i && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/mesh_xbar_reg.sv
// Registered IN_N x OUT_N crossbar with per-output source select, multicast
// and all-or-nothing input ready. Per-output flit counters under XBAR_FLIT_CNT_EN.
module mesh_xbar_reg
  import mesh_xbar_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_N       = 5,
  parameter int OUT_N      = 5,
`ifdef XBAR_FLIT_CNT_EN
  parameter int CNT_WIDTH  = 16,
`endif
  localparam int SEL_W     = sel_width(IN_N)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [IN_N*DATA_WIDTH-1:0]  in_data_i,
  input  logic [IN_N-1:0]             in_valid_i,
  output logic [IN_N-1:0]             in_ready_o,
  input  logic [OUT_N*SEL_W-1:0]      out_sel_i,
  input  logic [OUT_N-1:0]            out_en_i,
  output logic [OUT_N*DATA_WIDTH-1:0] out_data_o,
  output logic [OUT_N-1:0]            out_valid_o,
  input  logic [OUT_N-1:0]            out_ready_i,
`ifdef XBAR_FLIT_CNT_EN
  output logic [OUT_N*CNT_WIDTH-1:0]  flit_cnt_o,
`endif
  output logic                        sel_err_o
);

  logic [SEL_W-1:0]      sel_s      [OUT_N];
  logic [DATA_WIDTH-1:0] mux_data_s [OUT_N];
  logic [OUT_N-1:0]      conn_s;
  logic [OUT_N-1:0]      bad_sel_s;
  logic [OUT_N-1:0]      can_load_s;
  logic [OUT_N-1:0]      load_s;
  logic [IN_N-1:0]       in_ready_s;
  logic [IN_N-1:0]       xfer_s;
  logic                  sel_err_d, sel_err_q;

  // Decode each output's selector; out-of-range values drop the connection.
  always_comb begin : decode
    logic in_range;
    for (int o = 0; o < OUT_N; o++) begin
      sel_s[o]      = out_sel_i[field_lsb(o, SEL_W) +: SEL_W];
      in_range      = (int'(sel_s[o]) < IN_N);
      conn_s[o]     = out_en_i[o] & in_range;
      bad_sel_s[o]  = out_en_i[o] & ~in_range;
      can_load_s[o] = ~out_valid_o[o] | out_ready_i[o];
    end
  end

  // An input is ready only if it has a target and every target can load.
  always_comb begin : ready_calc
    logic hit;
    logic blocked;
    logic match;
    for (int i = 0; i < IN_N; i++) begin
      hit     = 1'b0;
      blocked = 1'b0;
      for (int o = 0; o < OUT_N; o++) begin
        match   = conn_s[o] & (sel_s[o] == SEL_W'(i));
        hit     = hit | match;
        blocked = blocked | (match & ~can_load_s[o]);
      end
      in_ready_s[i] = hit & ~blocked & ~rst_i;
    end
    xfer_s = in_valid_i & in_ready_s;
  end

  // Per-output source mux and load strobe.
  always_comb begin : out_mux
    logic match;
    for (int o = 0; o < OUT_N; o++) begin
      mux_data_s[o] = '0;
      load_s[o]     = 1'b0;
      for (int i = 0; i < IN_N; i++) begin
        match         = (sel_s[o] == SEL_W'(i));
        mux_data_s[o] = mux_data_s[o] |
                        ({DATA_WIDTH{match}} & in_data_i[field_lsb(i, DATA_WIDTH) +: DATA_WIDTH]);
        load_s[o]     = load_s[o] | (conn_s[o] & match & xfer_s[i]);
      end
    end
  end

  assign in_ready_o = in_ready_s;

  always_comb begin
    sel_err_d = |bad_sel_s;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err_o = sel_err_q;

  for (genvar o = 0; o < OUT_N; o++) begin : g_out
    xbar_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
`ifdef XBAR_FLIT_CNT_EN
      ,
      .CNT_WIDTH  (CNT_WIDTH)
`endif
    ) u_out_reg (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (load_s[o]),
      .data_i  (mux_data_s[o]),
      .ready_i (out_ready_i[o]),
`ifdef XBAR_FLIT_CNT_EN
      .cnt_o   (flit_cnt_o[field_lsb(o, CNT_WIDTH) +: CNT_WIDTH]),
`endif
      .data_o  (out_data_o[field_lsb(o, DATA_WIDTH) +: DATA_WIDTH]),
      .valid_o (out_valid_o[o])
    );
  end

endmodule

// File: tb/tb_mesh_xbar_reg.sv
// Self-checking bench for mesh_xbar_reg: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_mesh_xbar_reg;
  import mesh_xbar_pkg::*;

  localparam int DW = 8;
  localparam int NI = 5;
  localparam int NO = 5;
  localparam int SW = 3;
`ifdef XBAR_FLIT_CNT_EN
  localparam int CW = 2;
  logic [NO*CW-1:0] flit_cnt;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NI*DW-1:0] in_data;
  logic [NI-1:0]    in_valid;
  logic [NI-1:0]    in_ready;
  logic [NO*SW-1:0] out_sel;
  logic [NO-1:0]    out_en;
  logic [NO*DW-1:0] out_data;
  logic [NO-1:0]    out_valid;
  logic [NO-1:0]    out_ready;
  logic             sel_err;

  always #5 clk = ~clk;

  mesh_xbar_reg #(
    .DATA_WIDTH (DW),
    .IN_N       (NI),
    .OUT_N      (NO)
`ifdef XBAR_FLIT_CNT_EN
    ,
    .CNT_WIDTH  (CW)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_sel_i   (out_sel),
    .out_en_i    (out_en),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
`ifdef XBAR_FLIT_CNT_EN
    .flit_cnt_o  (flit_cnt),
`endif
    .sel_err_o   (sel_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_sel(input int o, input int v);
    out_sel[o*SW +: SW] = SW'(v);
  endtask

  task automatic set_din(input int i, input logic [DW-1:0] d);
    in_data[i*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] dout(input int o);
    return out_data[o*DW +: DW];
  endfunction

  // Behavioural model: which outputs does each input feed, and are they all free?
  bit            m_valid [NO];
  logic [DW-1:0] m_data  [NO];
  bit            m_err;

  function automatic int sel_of(input int o);
    return int'(out_sel[o*SW +: SW]);
  endfunction

  function automatic logic [NI-1:0] model_ready();
    logic [NI-1:0] r;
    for (int i = 0; i < NI; i++) begin
      int targets = 0;
      int free = 0;
      for (int o = 0; o < NO; o++) begin
        if (out_en[o] && sel_of(o) == i) begin
          targets++;
          if (!m_valid[o] || out_ready[o]) free++;
        end
      end
      r[i] = (targets > 0) && (free == targets) && !rst;
    end
    return r;
  endfunction

  task automatic model_clock();
    logic [NI-1:0] r;
    r = model_ready();
    m_err = 1'b0;
    for (int o = 0; o < NO; o++) begin
      int s = sel_of(o);
      if (out_en[o] && s >= NI) m_err = 1'b1;
      if (out_en[o] && s < NI && in_valid[s] && r[s]) begin
        m_valid[o] = 1'b1;
        m_data[o]  = in_data[s*DW +: DW];
      end else if (out_ready[o]) begin
        m_valid[o] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < NO; o++) begin
      m_valid[o] = 1'b0;
      m_data[o]  = '0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [NO*DW-1:0] model_data();
    logic [NO*DW-1:0] v;
    for (int o = 0; o < NO; o++) v[o*DW +: DW] = m_data[o];
    return v;
  endfunction

  function automatic logic [NO-1:0] model_valid();
    logic [NO-1:0] v;
    for (int o = 0; o < NO; o++) v[o] = m_valid[o];
    return v;
  endfunction

  task automatic clear_inputs();
    in_data   = '0;
    in_valid  = '0;
    out_sel   = '0;
    out_en    = '0;
    out_ready = '1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct packed {
    logic [NI*DW-1:0] din;
    logic [NI-1:0]    vin;
    logic [NO*SW-1:0] sel;
    logic [NO-1:0]    en;
    logic [NO-1:0]    rdy;
    logic [NI-1:0]    exp_ir;
    logic [NO-1:0]    exp_ov;
    logic [NO*DW-1:0] exp_od;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // WEST -> EAST unicast, then LOCAL -> SOUTH with NORTH -> LOCAL.
    vecs[0] = '{{8'hA1, 32'h0}, 5'b10000, {3'd0,3'd0,3'd4,3'd0,3'd0}, 5'b00100, 5'b11111,
                5'b10000, 5'b00100, {16'h0, 8'hA1, 16'h0}};
    vecs[1] = '{{8'hA2, 32'h0}, 5'b10000, {3'd0,3'd0,3'd4,3'd0,3'd0}, 5'b00100, 5'b11111,
                5'b10000, 5'b00100, {16'h0, 8'hA2, 16'h0}};
    vecs[2] = '{{8'hA3, 32'h0}, 5'b10000, {3'd0,3'd0,3'd4,3'd0,3'd0}, 5'b00100, 5'b11111,
                5'b10000, 5'b00100, {16'h0, 8'hA3, 16'h0}};
    vecs[3] = '{40'h0, 5'b00000, {3'd0,3'd0,3'd4,3'd0,3'd0}, 5'b00100, 5'b11111,
                5'b10000, 5'b00000, {16'h0, 8'hA3, 16'h0}};
    vecs[4] = '{{24'h0, 8'h41, 8'h31}, 5'b00011, {3'd0,3'd0,3'd0,3'd0,3'd1}, 5'b01001, 5'b11111,
                5'b00011, 5'b01001, {8'h00, 8'h31, 8'hA3, 8'h00, 8'h41}};
    vecs[5] = '{{24'h0, 8'h42, 8'h32}, 5'b00011, {3'd0,3'd0,3'd0,3'd0,3'd1}, 5'b01001, 5'b11111,
                5'b00011, 5'b01001, {8'h00, 8'h32, 8'hA3, 8'h00, 8'h42}};
    vecs[6] = '{{24'h0, 8'h43, 8'h33}, 5'b00011, {3'd0,3'd0,3'd0,3'd0,3'd1}, 5'b01001, 5'b10111,
                5'b00010, 5'b01001, {8'h00, 8'h32, 8'hA3, 8'h00, 8'h43}};
    vecs[7] = '{{24'h0, 8'h44, 8'h34}, 5'b00011, {3'd0,3'd0,3'd0,3'd0,3'd1}, 5'b01001, 5'b11111,
                5'b00011, 5'b01001, {8'h00, 8'h34, 8'hA3, 8'h00, 8'h44}};

    rst = 1'b1;
    clear_inputs();
    out_en = '1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", in_ready, '0);
    chk("rst_sel_err", sel_err, 1'b0);
    rst = 1'b0;
    out_en = '0;

    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      in_data   = vecs[r].din;
      in_valid  = vecs[r].vin;
      out_sel   = vecs[r].sel;
      out_en    = vecs[r].en;
      out_ready = vecs[r].rdy;
      #1;
      chk($sformatf("vec%0d_in_ready", r), in_ready, vecs[r].exp_ir);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", r), out_valid, vecs[r].exp_ov);
      chk($sformatf("vec%0d_out_data", r), out_data, vecs[r].exp_od);
    end

    // Asynchronous reset in the middle of traffic.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, '0);
    chk("async_rst_out_data", out_data, '0);
    chk("async_rst_in_ready", in_ready, '0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    chk("post_rst_idle_valid", out_valid, '0);

    // EAST multicasts to NORTH and WEST; WEST stalls.
    @(negedge clk);
    set_sel(NORTH, EAST);
    set_sel(WEST, EAST);
    out_en   = 5'b10010;
    in_valid = 5'b00100;
    set_din(EAST, 8'h5A);
    @(posedge clk);
    #1;
    chk("mc_load_valid", out_valid, 5'b10010);
    chk("mc_load_out1", dout(NORTH), 8'h5A);
    chk("mc_load_out4", dout(WEST), 8'h5A);
    @(negedge clk);
    out_ready[WEST] = 1'b0;
    set_din(EAST, 8'h5B);
    #1;
    chk("mc_stall_in_ready", in_ready, 5'b00000);
    @(posedge clk);
    #1;
    chk("mc_stall_valid", out_valid, 5'b10000);
    chk("mc_stall_out1_hold", dout(NORTH), 8'h5A);
    chk("mc_stall_out4_hold", dout(WEST), 8'h5A);
    @(negedge clk);
    out_ready = '1;
    set_din(EAST, 8'h5C);
    #1;
    chk("mc_release_in_ready", in_ready, 5'b00100);
    @(posedge clk);
    #1;
    chk("mc_release_valid", out_valid, 5'b10010);
    chk("mc_release_out1", dout(NORTH), 8'h5C);
    chk("mc_release_out4", dout(WEST), 8'h5C);

    // Selector moves while LOCAL output is stalled.
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    out_en    = 5'b00001;
    set_sel(LOCAL, NORTH);
    out_ready = '0;
    in_valid  = 5'b00010;
    set_din(NORTH, 8'h11);
    @(posedge clk);
    #1;
    chk("selchg_load", {out_valid[LOCAL], dout(LOCAL)}, {1'b1, 8'h11});
    @(negedge clk);
    set_sel(LOCAL, SOUTH);
    in_valid = 5'b01000;
    set_din(SOUTH, 8'h77);
    #1;
    chk("selchg_stall_in_ready", in_ready, 5'b00000);
    @(posedge clk);
    #1;
    chk("selchg_hold", {out_valid[LOCAL], dout(LOCAL)}, {1'b1, 8'h11});
    @(negedge clk);
    out_ready[LOCAL] = 1'b1;
    #1;
    chk("selchg_free_in_ready", in_ready, 5'b01000);
    @(posedge clk);
    #1;
    chk("selchg_new_src", {out_valid[LOCAL], dout(LOCAL)}, {1'b1, 8'h77});

    // Out-of-range selector.
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    out_en   = 5'b00010;
    set_sel(NORTH, 7);
    in_valid = '1;
    in_data  = 40'hFFEEDDCCBB;
    #1;
    chk("badsel_in_ready", in_ready, 5'b00000);
    @(posedge clk);
    #1;
    chk("badsel_err", sel_err, 1'b1);
    chk("badsel_no_load", out_valid, 5'b00000);
    @(negedge clk);
    out_en = '0;
    @(posedge clk);
    #1;
    chk("badsel_err_clear", sel_err, 1'b0);

`ifdef XBAR_FLIT_CNT_EN
    do_reset();
    set_sel(EAST, WEST);
    out_en = 5'b00100;
    in_valid[WEST] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_din(WEST, 8'(8'hC0 + k));
      @(negedge clk);
    end
    in_valid = '0;
    @(posedge clk);
    #1;
    chk("cnt_three", flit_cnt[EAST*CW +: CW], 2'd3);
    @(negedge clk);
    chk("cnt_saturated", flit_cnt[EAST*CW +: CW], 2'd3);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      in_data   = 40'({$urandom(), $urandom()});
      in_valid  = 5'($urandom());
      out_sel   = 15'($urandom());
      out_en    = 5'($urandom());
      out_ready = 5'($urandom() | $urandom());
      #1;
      chk("rnd_in_ready", in_ready, model_ready());
      model_clock();
      @(posedge clk);
      #1;
      chk("rnd_out_valid", out_valid, model_valid());
      chk("rnd_out_data", out_data, model_data());
      chk("rnd_sel_err", sel_err, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
